wb_ioc_mux: RTL
===============

# wb_ioc_mux

Parametrised single-master, N-slave Wishbone classic I/O interconnect for the wb_soc peripheral fabric, replacing the fixed three-port interconnect. Decodes each master cycle against a base/mask address map, forwards it to one slave through a registered request/response stage, and returns ack/err/rty to the master. Unmapped addresses and, optionally, hung slaves return a bus error instead of stalling. Both cases capture the failing address.

## Interface
- NUM_SLAVES, 4: number of slave ports (1..16).
- AW, 32: address width.
- DW, 32: data width; SW = DW/8 select bits.
- SLAVE_BASE, {NUM_SLAVES{AW'0}}: packed base addresses; slot i = bits [i*AW +: AW].
- SLAVE_MASK, {NUM_SLAVES{AW'0}}: packed decode masks; a slave hits when (adr & mask) == base.
- TIMEOUT_CYCLES, 255: maximum cycles a slave may stall before an error is returned (1..65535).
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wb_io_adr_i / wb_io_dat_i / wb_io_sel_i / wb_io_we_i  in  AW/DW/SW/1  master request.
- wb_io_cyc_i / wb_io_stb_i  in  1  master cycle and strobe.
- wb_io_dat_o  out  DW  read data, registered.
- wb_io_ack_o / wb_io_err_o / wb_io_rty_o  out  1  one-cycle response pulses, mutually exclusive.
- wb_s_adr_o / wb_s_dat_o / wb_s_sel_o / wb_s_we_o  out  AW/DW/SW/1  latched request, broadcast to all slaves.
- wb_s_cyc_o / wb_s_stb_o  out  NUM_SLAVES  one-hot per-slave cycle and strobe.
- wb_s_dat_i  in  NUM_SLAVES*DW  packed slave read data.
- wb_s_ack_i / wb_s_err_i / wb_s_rty_i  in  NUM_SLAVES  slave responses.
- err_adr_o  out  AW  address of the most recent errored access.
- err_valid_o  out  1  sticky flag; set by any interconnect-generated error, cleared only by reset.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: on cyc&stb, latch adr/dat/sel/we and decode. On a hit, latch slave index g (lowest index wins on overlap) and go to BUSY. On a miss, set the response to err, load err_adr_o, set err_valid_o, and go to RESP.
- BUSY: wb_s_cyc_o[g] and wb_s_stb_o[g] are high; all other bits are 0. On ack, err or rty from slave g (priority ack > err > rty), capture wb_s_dat_i slot g on ack and record the response. Then drop the slave strobe and go to RESP.
- RESP: drive the recorded response pulse for exactly one cycle, then go to IDLE.
- Master abort: cyc_i low in BUSY drops the slave cyc/stb in the next cycle, returns to IDLE, and issues no response.
- Responses from non-granted slaves are ignored.
- wb_io_dat_o holds its value between reads and is unchanged by writes and errors.
- Reset mid-transaction: go to IDLE immediately; all outputs return to reset values.

## Timing
- Reset values: all *_o are 0, the FSM is in IDLE, and the timeout counter is 0.
- Zero-wait slave (acks in the first cycle its stb is high):
  - request seen in IDLE at cycle 0;
  - slave stb high at cycle 1;
  - master ack at cycle 2.
- Total latency is 2 + slave wait states.
- Unmapped access: request at cycle 0, wb_io_err_o at cycle 1.
- The master must hold stb until the response and drop it after the response edge. In IDLE, the cycle after RESP accepts a new request, giving back-to-back throughput of one access per 3 cycles minimum.

## Configuration
- WB_IOC_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no slave response: drop the slave strobe, return err through RESP, load err_adr_o, and set err_valid_o.
  - A slave response arriving in the same cycle as expiry wins.
- WB_IOC_TIMEOUT_EN undefined:
  - No counter; BUSY waits indefinitely.
  - TIMEOUT_CYCLES is ignored.
  - err_valid_o is set only by decode misses.

## Structure
- wb_ioc_pkg holds:
  - the state enum (IDLE/BUSY/RESP) and the response enum (RSP_ACK/RSP_ERR/RSP_RTY);
  - the default wb_soc address-map constants (UART, SPI1, SPI2 base/mask);
  - the MAX_SLAVES = 16 constant.
- One sub-module, wb_ioc_decode: combinational base/mask match producing hit, a one-hot match vector and a priority-encoded index. Instantiated once in wb_ioc_mux.

## Test plan
- NUM_SLAVES=3 with the map 0x000/0x100/0x200, mask 0xF00. Write 0xDEADBEEF to 0x104 -> only wb_s_stb_o[1] high with dat 0xDEADBEEF; slave acks immediately -> wb_io_ack_o at cycle 2.
- Read 0x208, slave 2 returns 0x5A after 3 wait states -> wb_io_dat_o=0x5A and ack at cycle 5; the data is held through a following write.
- Access 0x300 (unmapped) -> wb_io_err_o at cycle 1, no slave strobe, err_adr_o=0x300, err_valid_o=1.
- WB_IOC_TIMEOUT_EN with TIMEOUT_CYCLES=8 and slave 0 silent -> err after 8 BUSY cycles and slave stb dropped. A second run with the ack on the expiry cycle -> ack, not err.
- Slave 1 responds with rty -> one wb_io_rty_o pulse. A stray ack from slave 0 during the same access is ignored.
- Master drops cyc during BUSY -> slave cyc low in the next cycle, no response pulse. Assert wb_rst_i mid-BUSY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/wb_ioc_pkg.sv
// wb_ioc_pkg: shared types and default wb_soc map for the Wishbone I/O interconnect.
// Holds the FSM/response enums, MAX_SLAVES and the UART/SPI1/SPI2 decode constants.
package wb_ioc_pkg;

  localparam int MAX_SLAVES = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } ioc_state_e;

  typedef enum logic [1:0] {
    RSP_ACK,
    RSP_ERR,
    RSP_RTY
  } ioc_rsp_e;

  localparam logic [31:0] UART_BASE = 32'h0000_0000;
  localparam logic [31:0] UART_MASK = 32'h0000_0F00;
  localparam logic [31:0] SPI1_BASE = 32'h0000_0100;
  localparam logic [31:0] SPI1_MASK = 32'h0000_0F00;
  localparam logic [31:0] SPI2_BASE = 32'h0000_0200;
  localparam logic [31:0] SPI2_MASK = 32'h0000_0F00;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_ioc_decode.sv
// wb_ioc_decode: base/mask address match for the I/O interconnect.
// Lowest matching slot wins when map entries overlap.
module wb_ioc_decode
  import wb_ioc_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int AW = 32,
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_MASK = '0,
  localparam int IW = idx_w(NUM_SLAVES)
) (
  input  logic [AW-1:0]         adr,
  output logic                  hit,
  output logic [NUM_SLAVES-1:0] match,
  output logic [IW-1:0]         idx
);

  always_comb begin
    match = '0;
    idx   = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      match[i] = (adr & SLAVE_MASK[i*AW +: AW])
              == SLAVE_BASE[i*AW +: AW];
      if (match[i]) idx = IW'(i);
    end
  end

  assign hit = |match;

endmodule

// File: rtl/wb_ioc_mux.sv
// wb_ioc_mux: single-master, N-slave Wishbone classic I/O interconnect.
// Optional slave-hang timeout is enabled by defining WB_IOC_TIMEOUT_EN.
module wb_ioc_mux
  import wb_ioc_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8,
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [AW-1:0]            wb_io_adr_i,
  input  logic [DW-1:0]            wb_io_dat_i,
  input  logic [SW-1:0]            wb_io_sel_i,
  input  logic                     wb_io_we_i,
  input  logic                     wb_io_cyc_i,
  input  logic                     wb_io_stb_i,
  output logic [DW-1:0]            wb_io_dat_o,
  output logic                     wb_io_ack_o,
  output logic                     wb_io_err_o,
  output logic                     wb_io_rty_o,
  output logic [AW-1:0]            wb_s_adr_o,
  output logic [DW-1:0]            wb_s_dat_o,
  output logic [SW-1:0]            wb_s_sel_o,
  output logic                     wb_s_we_o,
  output logic [NUM_SLAVES-1:0]    wb_s_cyc_o,
  output logic [NUM_SLAVES-1:0]    wb_s_stb_o,
  input  logic [NUM_SLAVES*DW-1:0] wb_s_dat_i,
  input  logic [NUM_SLAVES-1:0]    wb_s_ack_i,
  input  logic [NUM_SLAVES-1:0]    wb_s_err_i,
  input  logic [NUM_SLAVES-1:0]    wb_s_rty_i,
  output logic [AW-1:0]            err_adr_o,
  output logic                     err_valid_o
);

  localparam int IW = idx_w(NUM_SLAVES);

  ioc_state_e state, state_n;
  ioc_rsp_e   rsp;

  logic [IW-1:0]         gnt;
  logic [NUM_SLAVES-1:0] gnt_oh;
  logic                  hit;
  logic [NUM_SLAVES-1:0] match;
  logic [IW-1:0]         idx;
  logic                  req;
  logic                  s_ack, s_err, s_rty;
  logic [DW-1:0]         s_rdat;
  logic                  expire;

  wb_ioc_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .AW         (AW),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .adr   (wb_io_adr_i),
    .hit   (hit),
    .match (match),
    .idx   (idx)
  );

  assign req    = wb_io_cyc_i & wb_io_stb_i;
  assign s_ack  = wb_s_ack_i[gnt];
  assign s_err  = wb_s_err_i[gnt];
  assign s_rty  = wb_s_rty_i[gnt];
  assign s_rdat = wb_s_dat_i[gnt*DW +: DW];

`ifdef WB_IOC_TIMEOUT_EN
  logic [15:0] tcnt;

  // Held at zero outside BUSY, so it is clear on every BUSY entry.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)          tcnt <= '0;
    else if (state == BUSY) tcnt <= tcnt + 16'd1;
    else                   tcnt <= '0;
  end

  assign expire = (state == BUSY)
               && (tcnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT_CYCLES);
  assign expire     = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (req) state_n = hit ? BUSY : RESP;
      BUSY: begin
        if (!wb_io_cyc_i)
          state_n = IDLE;
        else if (s_ack | s_err | s_rty | expire)
          state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    wb_s_cyc_o  = '0;
    wb_s_stb_o  = '0;
    wb_io_ack_o = 1'b0;
    wb_io_err_o = 1'b0;
    wb_io_rty_o = 1'b0;
    unique case (state)
      BUSY: begin
        wb_s_cyc_o = gnt_oh;
        wb_s_stb_o = gnt_oh;
      end
      RESP: begin
        wb_io_ack_o = (rsp == RSP_ACK);
        wb_io_err_o = (rsp == RSP_ERR);
        wb_io_rty_o = (rsp == RSP_RTY);
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rsp         <= RSP_ACK;
      gnt         <= '0;
      gnt_oh      <= '0;
      wb_s_adr_o  <= '0;
      wb_s_dat_o  <= '0;
      wb_s_sel_o  <= '0;
      wb_s_we_o   <= 1'b0;
      wb_io_dat_o <= '0;
      err_adr_o   <= '0;
      err_valid_o <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        wb_s_adr_o <= wb_io_adr_i;
        wb_s_dat_o <= wb_io_dat_i;
        wb_s_sel_o <= wb_io_sel_i;
        wb_s_we_o  <= wb_io_we_i;
        gnt        <= idx;
        // Isolate the lowest set match bit.
        gnt_oh     <= match & (~match + NUM_SLAVES'(1));
        if (!hit) begin
          rsp         <= RSP_ERR;
          err_adr_o   <= wb_io_adr_i;
          err_valid_o <= 1'b1;
        end
      end
      if (state == BUSY && wb_io_cyc_i) begin
        if (s_ack) begin
          rsp <= RSP_ACK;
          if (!wb_s_we_o) wb_io_dat_o <= s_rdat;
        end else if (s_err) begin
          rsp <= RSP_ERR;
        end else if (s_rty) begin
          rsp <= RSP_RTY;
        end else if (expire) begin
          rsp         <= RSP_ERR;
          err_adr_o   <= wb_s_adr_o;
          err_valid_o <= 1'b1;
        end
      end
    end
  end

endmodule
